// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter_pkg
//  Purpose  : Shared definitions for the SDRAM command-port arbiter:
//             FSM state encodings, requester port identifiers and the
//             default starvation / timeout limits.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PORT_VDP = 2'd0,
    PORT_CPU = 2'd1,
    PORT_MC  = 2'd2
  } port_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_pick
//  Purpose  : Winner selection for the SDRAM arbiter. VDP has priority
//             unless the low ports have been starved for STARVE_LIMIT
//             consecutive VDP grants; CPU and micom share round robin.
//  Ports    : clk, reset_n      clock / async active-low reset
//             en                arbitration allowed this cycle
//             vdp_req/cpu_req/mc_req  pending requests
//             grant_valid       a winner is chosen (only while en)
//             grant_port        the winner
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arb_pick
  import sdram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  en,
  input  logic  vdp_req,
  input  logic  cpu_req,
  input  logic  mc_req,
  output logic  grant_valid,
  output port_t grant_port
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic          rr_mc;        // 0: CPU preferred next, 1: micom preferred next
  logic [SW-1:0] starve_cnt;
  logic          low_wait;
  logic          starved;
  port_t         low_port;

  always_comb begin
    low_wait    = cpu_req | mc_req;
    starved     = low_wait && (starve_cnt == LIMIT);
    if (cpu_req && mc_req) begin
      low_port = rr_mc ? PORT_MC : PORT_CPU;
    end else if (cpu_req) begin
      low_port = PORT_CPU;
    end else begin
      low_port = PORT_MC;
    end
    grant_valid = 1'b0;
    grant_port  = PORT_VDP;
    if (en) begin
      if (vdp_req && !starved) begin
        grant_valid = 1'b1;
        grant_port  = PORT_VDP;
      end else if (low_wait) begin
        grant_valid = 1'b1;
        grant_port  = low_port;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_mc      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (grant_valid && grant_port == PORT_CPU) begin
        rr_mc <= 1'b1;
      end else if (grant_valid && grant_port == PORT_MC) begin
        rr_mc <= 1'b0;
      end
      // Count only VDP grants that overtook a waiting low port.
      if (!low_wait) begin
        starve_cnt <= '0;
      end else if (grant_valid) begin
        if (grant_port == PORT_VDP) begin
          if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Shares the single ip_sdram command port between VDP, the Z80
//             memory path and the micom loader. One access at a time:
//             IDLE -> ISSUE -> WAIT -> ACK, with a done timeout.
//  Ports    : clk, reset_n                     clock / async active-low reset
//             vdp_*   VDP requester (17-bit word address, 16-bit read data)
//             cpu_*   Z80 requester (23-bit address, byte read data)
//             mc_*    micom loader (writes only)
//             mem_*   command / response interface to ip_sdram
//             timeout_err                     sticky done-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter logic [22:0] VDP_BASE     = 23'h000000,
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int          TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_req,
  input  logic        vdp_write,
  input  logic [16:0] vdp_address,
  input  logic [7:0]  vdp_wdata,
  output logic [15:0] vdp_rdata,
  output logic        vdp_ack,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [22:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        mc_req,
  input  logic [22:0] mc_address,
  input  logic [7:0]  mc_wdata,
  output logic        mc_ack,
  input  logic        mem_busy,
  output logic        mem_req,
  output logic        mem_write,
  output logic [22:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        timeout_err
);

  state_t      state;
  state_t      state_nx;
  port_t       owner;
  port_t       grant_port;
  logic        grant_valid;
  logic        hold;
  logic        arb_en;
  logic        timed_out;
  logic [7:0]  tcnt;
  logic [15:0] rd_buf;
  logic [22:0] vdp_addr_ext;

  // The ack cycle is the first IDLE cycle; the served requester still holds
  // req there, so no arbitration happens until it has had a chance to drop.
  assign hold         = vdp_ack | cpu_ack | mc_ack;
  assign arb_en       = (state == ST_IDLE) && !mem_busy && !hold;
  assign timed_out    = (tcnt == 8'(TIMEOUT));
  assign vdp_addr_ext = VDP_BASE + {6'b0, vdp_address};  // wraps modulo 2^23

  sdram_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (arb_en),
    .vdp_req     (vdp_req),
    .cpu_req     (cpu_req),
    .mc_req      (mc_req),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant_valid) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (mem_done || timed_out) state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= PORT_VDP;
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      tcnt        <= '0;
      rd_buf      <= '0;
      vdp_rdata   <= '0;
      cpu_rdata   <= '0;
      vdp_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      mc_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_req <= (state == ST_ISSUE);
      vdp_ack <= 1'b0;
      cpu_ack <= 1'b0;
      mc_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner <= grant_port;
            case (grant_port)
              PORT_VDP: begin
                mem_write   <= vdp_write;
                mem_address <= vdp_addr_ext;
                mem_wdata   <= vdp_wdata;
              end
              PORT_CPU: begin
                mem_write   <= cpu_write;
                mem_address <= cpu_address;
                mem_wdata   <= cpu_wdata;
              end
              default: begin
                mem_write   <= 1'b1;
                mem_address <= mc_address;
                mem_wdata   <= mc_wdata;
              end
            endcase
          end
        end
        ST_ISSUE: tcnt <= '0;
        ST_WAIT: begin
          if (mem_done) begin
            rd_buf <= mem_rdata;
          end else if (timed_out) begin
            rd_buf      <= '1;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_ACK: begin
          case (owner)
            PORT_VDP: begin
              vdp_ack   <= 1'b1;
              vdp_rdata <= rd_buf;
            end
            PORT_CPU: begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= mem_address[0] ? rd_buf[15:8] : rd_buf[7:0];
            end
            default: mc_ack <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Directed self-checking bench for sdram_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vdp_req, vdp_write;
  logic [16:0] vdp_address;
  logic [7:0]  vdp_wdata;
  logic [15:0] vdp_rdata;
  logic        vdp_ack;
  logic        cpu_req, cpu_write;
  logic [22:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        mc_req;
  logic [22:0] mc_address;
  logic [7:0]  mc_wdata;
  logic        mc_ack;
  logic        mem_busy;
  logic        mem_req, mem_write;
  logic [22:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .VDP_BASE     (23'h000000),
    .STARVE_LIMIT (4),
    .TIMEOUT      (TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vdp_req(vdp_req), .vdp_write(vdp_write), .vdp_address(vdp_address),
    .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata), .vdp_ack(vdp_ack),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mc_req(mc_req), .mc_address(mc_address), .mc_wdata(mc_wdata), .mc_ack(mc_ack),
    .mem_busy(mem_busy), .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .timeout_err(timeout_err)
  );

  // Requesters use disjoint address ranges: 2xxxxx = CPU, 3xxxxx = micom.
  function automatic int port_of(input logic [22:0] a);
    if (a[22:20] == 3'd2) return 1;
    if (a[22:20] == 3'd3) return 2;
    return 0;
  endfunction

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic core_reply(input logic [15:0] d);
    @(negedge clk);
    mem_rdata = d;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    reset_n = 1'b0; mem_busy = 1'b1; mem_done = 1'b0; mem_rdata = '0;
    vdp_req = 1'b1; vdp_write = 1'b0; vdp_address = 17'h00100; vdp_wdata = 8'h00;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 23'h200000; cpu_wdata = 8'h00;
    mc_req  = 1'b1; mc_address = 23'h300000; mc_wdata = 8'h00;
    #12;
    checks++;
    if ({mem_req, mem_write, mem_address, mem_wdata, vdp_rdata, vdp_ack,
         cpu_rdata, cpu_ack, mc_ack, timeout_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: outputs not all zero in reset");
    end
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (mem_req !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL busy_block: mem_req=1 while busy, required 0"); end
    mem_busy = 1'b0;
    wait_mem_req(ok);
    checks++;
    if (!ok || port_of(mem_address) != 0) begin
      errors++; $display("FAIL first_grant: ok=%0d port=%0d, required port 0", ok, port_of(mem_address));
    end
    cpu_req = 1'b0; mc_req = 1'b0;
    core_reply(16'h1111);
    @(negedge clk);
    checks++;
    if (vdp_ack !== 1'b1) begin errors++; $display("FAIL first_ack: vdp_ack=%b required 1", vdp_ack); end
    vdp_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_vdp_read();
    int extra;
    vdp_write = 1'b0; vdp_address = 17'h12345; vdp_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL vdp_lat1: mem_req=%b required 0", mem_req); end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_address !== 23'h012345 || mem_write !== 1'b0) begin
      errors++; $display("FAIL vdp_cmd: req=%b addr=%h wr=%b, required 1 012345 0", mem_req, mem_address, mem_write);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_address !== 23'h012345) begin
      errors++; $display("FAIL vdp_strobe: req=%b addr=%h, required 0 012345", mem_req, mem_address);
    end
    mem_rdata = 16'hBEEF; mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0; mem_rdata = '0;
    checks++;
    if (vdp_ack !== 1'b0) begin errors++; $display("FAIL vdp_ack_early: vdp_ack=%b required 0", vdp_ack); end
    @(negedge clk);
    checks++;
    if (vdp_ack !== 1'b1 || vdp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL vdp_ack: ack=%b rdata=%h, required 1 BEEF", vdp_ack, vdp_rdata);
    end
    vdp_req = 1'b0;
    extra = 0;
    repeat (5) begin @(negedge clk); if (vdp_ack || mem_req) extra++; end
    checks++;
    if (extra != 0 || vdp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL vdp_single: extra=%0d rdata=%h, required 0 BEEF", extra, vdp_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp;
    cpu_write = 1'b0; cpu_address = 23'h200001;
    mc_address = 23'h300000; mc_wdata = 8'h5A;
    cpu_req = 1'b1; mc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 1 : 2;
      wait_mem_req(ok);
      checks++;
      if (!ok || port_of(mem_address) != exp) begin
        errors++; $display("FAIL rr_order[%0d]: ok=%0d port=%0d required %0d", i, ok, port_of(mem_address), exp);
      end
      if (exp == 2) begin
        checks++;
        if (mem_write !== 1'b1 || mem_wdata !== 8'h5A) begin
          errors++; $display("FAIL mc_write: wr=%b wdata=%h required 1 5A", mem_write, mem_wdata);
        end
      end
      core_reply(16'hA55A);
      @(negedge clk);
      checks++;
      if (exp == 1) begin
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
          errors++; $display("FAIL cpu_rdata[%0d]: ack=%b rdata=%h required 1 A5", i, cpu_ack, cpu_rdata);
        end
      end else if (mc_ack !== 1'b1) begin
        errors++; $display("FAIL mc_ack[%0d]: mc_ack=%b required 1", i, mc_ack);
      end
      if (i == 3) begin cpu_req = 1'b0; mc_req = 1'b0; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_starvation();
    bit ok;
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    vdp_address = 17'h00100; cpu_address = 23'h200000;
    vdp_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_mem_req(ok);
      checks++;
      if (!ok || port_of(mem_address) != exp_order[i]) begin
        errors++; $display("FAIL starve_order[%0d]: ok=%0d port=%0d required %0d", i, ok, port_of(mem_address), exp_order[i]);
      end
      core_reply(16'h0000);
      @(negedge clk);
      if (i == 9) begin vdp_req = 1'b0; cpu_req = 1'b0; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    bit got;
    int n;
    cpu_write = 1'b0; cpu_address = 23'h200000; cpu_req = 1'b1;
    wait_mem_req(ok);
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk); n++;
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (!ok || !got || n != TO + 2) begin
      errors++; $display("FAIL timeout_lat: got=%0d cycles=%0d required %0d", got, n, TO + 2);
    end
    checks++;
    if (cpu_rdata !== 8'hFF || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_data: rdata=%h err=%b required FF 1", cpu_rdata, timeout_err);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    mc_address = 23'h300010; mc_wdata = 8'h33; mc_req = 1'b1;
    wait_mem_req(ok);
    core_reply(16'h0000);
    @(negedge clk);
    checks++;
    if (!ok || mc_ack !== 1'b1 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: ok=%0d ack=%b err=%b required 1 1 1", ok, mc_ack, timeout_err);
    end
    mc_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int acks;
    vdp_write = 1'b0; vdp_address = 17'h00200; vdp_req = 1'b1;
    wait_mem_req(ok);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_write, mem_address, mem_wdata, vdp_rdata, vdp_ack,
         cpu_rdata, cpu_ack, mc_ack, timeout_err} !== '0) begin
      errors++; $display("FAIL async_reset: outputs not zero, addr=%h err=%b", mem_address, timeout_err);
    end
    vdp_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    mem_rdata = 16'hDEAD; mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0; mem_rdata = '0;
    acks = 0;
    repeat (6) begin @(negedge clk); if (vdp_ack || cpu_ack || mc_ack || mem_req) acks++; end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL no_ack_after_reset: events=%0d required 0", acks); end
    vdp_address = 17'h00300; vdp_req = 1'b1;
    wait_mem_req(ok);
    checks++;
    if (!ok || mem_address !== 23'h000300) begin
      errors++; $display("FAIL post_reset_cmd: ok=%0d addr=%h required 000300", ok, mem_address);
    end
    core_reply(16'h1234);
    @(negedge clk);
    checks++;
    if (vdp_ack !== 1'b1 || vdp_rdata !== 16'h1234) begin
      errors++; $display("FAIL post_reset_ack: ack=%b rdata=%h required 1 1234", vdp_ack, vdp_rdata);
    end
    vdp_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vdp_read();
    test_round_robin();
    test_starvation();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
